// File: rtl/core_idu_pipe.sv
// core_idu_pipe: RV decode stage with immediate generation, EX/MEM operand
// forwarding, load-use hazard detection, branch resolve and an ID/EX register.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready, pc_i, instr_i IF/ID handshake and instruction
//   rs1_idx_o/rs2_idx_o              register-file read indices
//   rs1_rdata_i/rs2_rdata_i          register-file read data
//   ex_wen_i/ex_is_load_i/ex_rd_i/ex_result_i
//                                    EX-stage bypass source
//   mem_wen_i/mem_rd_i/mem_result_i  MEM-stage bypass source
//   idx_src_i                        branch base: pc_i or forwarded rs1
//   flush_i, stall_o                 kill request, hazard stall
//   pc_branch_o, br_flags_o          branch target and {eq, lt, ltu}
//   out_valid/out_ready              ID/EX handshake
//   pc_o, instr_o, imm_o, rd_o       registered instruction fields
//   rs1_data_o/rs2_data_o            registered forwarded operands
module core_idu_pipe #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned PC_W     = 64,
    parameter int unsigned RF_IDX_W = 5,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_W-1:0]     pc_i,
    input  logic [31:0]         instr_i,
    output logic [RF_IDX_W-1:0] rs1_idx_o,
    output logic [RF_IDX_W-1:0] rs2_idx_o,
    input  logic [XLEN-1:0]     rs1_rdata_i,
    input  logic [XLEN-1:0]     rs2_rdata_i,
    input  logic                ex_wen_i,
    input  logic                ex_is_load_i,
    input  logic [RF_IDX_W-1:0] ex_rd_i,
    input  logic [XLEN-1:0]     ex_result_i,
    input  logic                mem_wen_i,
    input  logic [RF_IDX_W-1:0] mem_rd_i,
    input  logic [XLEN-1:0]     mem_result_i,
    input  logic                idx_src_i,
    input  logic                flush_i,
    output logic [PC_W-1:0]     pc_branch_o,
    output logic [2:0]          br_flags_o,
    output logic                stall_o,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     pc_o,
    output logic [31:0]         instr_o,
    output logic [XLEN-1:0]     imm_o,
    output logic [RF_IDX_W-1:0] rd_o,
    output logic [XLEN-1:0]     rs1_data_o,
    output logic [XLEN-1:0]     rs2_data_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]          opcode;
    logic                is_i;
    logic                is_s;
    logic                is_b;
    logic                is_u;
    logic                is_j;
    logic [31:0]         imm32;
    logic [XLEN-1:0]     imm;
    logic [RF_IDX_W-1:0] rs1_idx;
    logic [RF_IDX_W-1:0] rs2_idx;
    logic [RF_IDX_W-1:0] rd_idx;
    logic                ex_hit1;
    logic                ex_hit2;
    logic                mem_hit1;
    logic                mem_hit2;
    logic                load_use;
    logic                raw_any;
    logic                hazard;
    logic                fire_out;
    logic [XLEN-1:0]     rs1_fwd;
    logic [XLEN-1:0]     rs2_fwd;
    logic [PC_W-1:0]     br_base;

    assign opcode  = instr_i[6:0];
    assign rs1_idx = RF_IDX_W'(instr_i[19:15]);
    assign rs2_idx = RF_IDX_W'(instr_i[24:20]);
    assign rd_idx  = RF_IDX_W'(instr_i[11:7]);

    assign rs1_idx_o = rs1_idx;
    assign rs2_idx_o = rs2_idx;

    // ---------------- immediate generation ----------------
    assign is_i = (opcode == OP_LOAD) || (opcode == OP_IMM) ||
                  (opcode == OP_IMM32) || (opcode == OP_JALR);
    assign is_s = (opcode == OP_STORE);
    assign is_b = (opcode == OP_BRANCH);
    assign is_u = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign is_j = (opcode == OP_JAL);

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            is_i: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            is_s: imm32 = {{20{instr_i[31]}}, instr_i[31:25],
                           instr_i[11:7]};
            is_b: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
            is_u: imm32 = {instr_i[31:12], 12'b0};
            is_j: imm32 = {{11{instr_i[31]}}, instr_i[31],
                           instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Widen to XLEN by replicating bit 31 across the full word first.
    always_comb begin
        imm        = {XLEN{imm32[31]}};
        imm[31:0]  = imm32;
    end

    // ---------------- RAW detection ----------------
    assign ex_hit1  = ex_wen_i && (ex_rd_i != '0) && (ex_rd_i == rs1_idx);
    assign ex_hit2  = ex_wen_i && (ex_rd_i != '0) && (ex_rd_i == rs2_idx);
    assign mem_hit1 = mem_wen_i && (mem_rd_i != '0) &&
                      (mem_rd_i == rs1_idx);
    assign mem_hit2 = mem_wen_i && (mem_rd_i != '0) &&
                      (mem_rd_i == rs2_idx);

    // A load in EX has no data yet, so it can never be bypassed.
    assign load_use = ex_is_load_i && (ex_hit1 || ex_hit2);
    assign raw_any  = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
    assign hazard   = in_valid && (load_use || (!FWD_EN && raw_any));

    assign stall_o  = hazard;
    assign fire_out = !out_valid || out_ready;
    assign in_ready = fire_out && !hazard && !flush_i;

    // ---------------- operand forwarding ----------------
    always_comb begin
        rs1_fwd = rs1_rdata_i;
        if (FWD_EN) begin
            if (ex_hit1 && !ex_is_load_i) begin
                rs1_fwd = ex_result_i;
            end else if (mem_hit1) begin
                rs1_fwd = mem_result_i;
            end
        end
    end

    always_comb begin
        rs2_fwd = rs2_rdata_i;
        if (FWD_EN) begin
            if (ex_hit2 && !ex_is_load_i) begin
                rs2_fwd = ex_result_i;
            end else if (mem_hit2) begin
                rs2_fwd = mem_result_i;
            end
        end
    end

    // ---------------- branch resolve ----------------
    assign br_base     = idx_src_i ? rs1_fwd[PC_W-1:0] : pc_i;
    assign pc_branch_o = br_base + imm[PC_W-1:0];
    assign br_flags_o  = {rs1_fwd == rs2_fwd,
                          $signed(rs1_fwd) < $signed(rs2_fwd),
                          rs1_fwd < rs2_fwd};

    // ---------------- ID/EX register ----------------
    // Bubbles and flushes only drop valid; the data fields keep their
    // last loaded value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            pc_o       <= '0;
            instr_o    <= '0;
            imm_o      <= '0;
            rd_o       <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
        end else if (flush_i) begin
            out_valid  <= 1'b0;
        end else if (fire_out && in_valid && !hazard) begin
            out_valid  <= 1'b1;
            pc_o       <= pc_i;
            instr_o    <= instr_i;
            imm_o      <= imm;
            rd_o       <= rd_idx;
            rs1_data_o <= rs1_fwd;
            rs2_data_o <= rs2_fwd;
        end else if (fire_out) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_idu_pipe.sv
// Self-checking bench for core_idu_pipe: three builds (64-bit forwarding,
// 32-bit forwarding, 64-bit without forwarding) against a behavioural model.
module tb_core_idu_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_out_ready = 1'b1;
    logic        s_flush = 1'b0;
    logic        s_idx_src = 1'b0;
    logic        s_exw = 1'b0;
    logic        s_exl = 1'b0;
    logic        s_memw = 1'b0;
    logic [4:0]  s_exrd = '0;
    logic [4:0]  s_memrd = '0;
    logic [31:0] s_instr = '0;
    logic [63:0] s_pc = '0;
    logic [63:0] s_rf1 = '0;
    logic [63:0] s_rf2 = '0;
    logic [63:0] s_exr = '0;
    logic [63:0] s_memr = '0;

    logic        o_inrdy [3];
    logic        o_stall [3];
    logic        o_valid [3];
    logic [2:0]  o_flags [3];
    logic [4:0]  o_rs1i [3];
    logic [4:0]  o_rs2i [3];
    logic [4:0]  o_rd [3];
    logic [31:0] o_instr [3];
    logic [63:0] o_br [3];
    logic [63:0] o_pc [3];
    logic [63:0] o_imm [3];
    logic [63:0] o_r1 [3];
    logic [63:0] o_r2 [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int W = (g == 1) ? 32 : 64;
        localparam bit F = (g != 2);
        logic [W-1:0] pc_b;
        logic [W-1:0] pco;
        logic [W-1:0] immo;
        logic [W-1:0] r1o;
        logic [W-1:0] r2o;

        core_idu_pipe #(
            .XLEN(W), .PC_W(W), .RF_IDX_W(5), .FWD_EN(F)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(s_in_valid), .in_ready(o_inrdy[g]),
            .pc_i(s_pc[W-1:0]), .instr_i(s_instr),
            .rs1_idx_o(o_rs1i[g]), .rs2_idx_o(o_rs2i[g]),
            .rs1_rdata_i(s_rf1[W-1:0]), .rs2_rdata_i(s_rf2[W-1:0]),
            .ex_wen_i(s_exw), .ex_is_load_i(s_exl),
            .ex_rd_i(s_exrd), .ex_result_i(s_exr[W-1:0]),
            .mem_wen_i(s_memw), .mem_rd_i(s_memrd),
            .mem_result_i(s_memr[W-1:0]),
            .idx_src_i(s_idx_src), .flush_i(s_flush),
            .pc_branch_o(pc_b), .br_flags_o(o_flags[g]),
            .stall_o(o_stall[g]), .out_valid(o_valid[g]),
            .out_ready(s_out_ready), .pc_o(pco),
            .instr_o(o_instr[g]), .imm_o(immo), .rd_o(o_rd[g]),
            .rs1_data_o(r1o), .rs2_data_o(r2o)
        );

        assign o_br[g]  = 64'(pc_b);
        assign o_pc[g]  = 64'(pco);
        assign o_imm[g] = 64'(immo);
        assign o_r1[g]  = 64'(r1o);
        assign o_r2[g]  = 64'(r2o);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int wid(int i);
        return (i == 1) ? 32 : 64;
    endfunction

    function automatic logic [63:0] tr(logic [63:0] x, int w);
        return (w == 32) ? {32'h0, x[31:0]} : x;
    endfunction

    // Immediate as a signed number assembled from weighted fields.
    function automatic longint m_imm(logic [31:0] ins);
        longint sg;
        sg = ins[31] ? 64'sd1 : 64'sd0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67:
                return longint'(ins[31:20]) - sg * 4096;
            7'h23:
                return longint'(ins[31:25]) * 32 + longint'(ins[11:7])
                       - sg * 4096;
            7'h63:
                return longint'(ins[7]) * 2048
                       + longint'(ins[30:25]) * 32
                       + longint'(ins[11:8]) * 2 - sg * 4096;
            7'h37, 7'h17:
                return longint'(ins[31:12]) * 4096 - sg * (64'sd1 << 32);
            7'h6F:
                return longint'(ins[19:12]) * 4096
                       + longint'(ins[20]) * 2048
                       + longint'(ins[30:21]) * 2 - sg * (64'sd1 << 20);
            default:
                return 0;
        endcase
    endfunction

    function automatic logic [63:0] m_fwd(logic [4:0] a, logic [63:0] rf,
                                          bit f);
        if (f && a != 0) begin
            if (s_exw && s_exrd == a && !s_exl) return s_exr;
            if (s_memw && s_memrd == a) return s_memr;
        end
        return rf;
    endfunction

    function automatic bit m_blk(logic [4:0] a, bit f);
        if (a == 0) return 1'b0;
        if (s_exw && s_exrd == a && (s_exl || !f)) return 1'b1;
        return !f && s_memw && s_memrd == a;
    endfunction

    function automatic logic [2:0] m_flags(logic [63:0] a,
                                           logic [63:0] b, int w);
        logic [63:0] at;
        logic [63:0] bt;
        longint sa;
        longint sb;
        at = tr(a, w);
        bt = tr(b, w);
        if (w == 32) begin
            sa = longint'($signed(at[31:0]));
            sb = longint'($signed(bt[31:0]));
        end else begin
            sa = $signed(at);
            sb = $signed(bt);
        end
        return {at == bt, sa < sb, at < bt};
    endfunction

    bit          m_v [3];
    bit          m_k [3];
    logic [63:0] m_pc [3];
    logic [63:0] m_im [3];
    logic [63:0] m_r1 [3];
    logic [63:0] m_r2 [3];
    logic [31:0] m_in [3];
    logic [4:0]  m_rd [3];
    bit          n_v [3];
    bit          n_k [3];
    logic [63:0] n_pc [3];
    logic [63:0] n_im [3];
    logic [63:0] n_r1 [3];
    logic [63:0] n_r2 [3];
    logic [31:0] n_in [3];
    logic [4:0]  n_rd [3];

    task automatic check_inst(int i);
        int w;
        bit f;
        bit hz;
        bit fire;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [63:0] v1;
        logic [63:0] v2;
        logic [63:0] im;
        logic [63:0] base;
        string p;
        w  = wid(i);
        f  = (i != 2);
        p  = $sformatf("u%0d", i);
        if (!rst_n) begin
            chk({p, " rst valid"}, 64'(o_valid[i]), 64'h0);
            chk({p, " rst pc"}, o_pc[i], 64'h0);
            chk({p, " rst instr"}, 64'(o_instr[i]), 64'h0);
            chk({p, " rst imm"}, o_imm[i], 64'h0);
            chk({p, " rst rd"}, 64'(o_rd[i]), 64'h0);
            chk({p, " rst rs1"}, o_r1[i], 64'h0);
            chk({p, " rst rs2"}, o_r2[i], 64'h0);
            n_v[i] = 0; n_k[i] = 1; n_pc[i] = 0; n_im[i] = 0;
            n_r1[i] = 0; n_r2[i] = 0; n_in[i] = 0; n_rd[i] = 0;
            return;
        end
        a1 = s_instr[19:15];
        a2 = s_instr[24:20];
        v1 = tr(m_fwd(a1, s_rf1, f), w);
        v2 = tr(m_fwd(a2, s_rf2, f), w);
        im = tr(64'(m_imm(s_instr)), w);
        hz = s_in_valid && (m_blk(a1, f) || m_blk(a2, f));
        fire = !m_v[i] || s_out_ready;
        base = s_idx_src ? v1 : tr(s_pc, w);
        chk({p, " rs1_idx"}, 64'(o_rs1i[i]), 64'(a1));
        chk({p, " rs2_idx"}, 64'(o_rs2i[i]), 64'(a2));
        chk({p, " stall"}, 64'(o_stall[i]), 64'(hz));
        chk({p, " in_ready"}, 64'(o_inrdy[i]),
            64'(fire && !hz && !s_flush));
        chk({p, " pc_branch"}, o_br[i], tr(base + im, w));
        if (!hz) chk({p, " flags"}, 64'(o_flags[i]),
                     64'(m_flags(v1, v2, w)));
        chk({p, " out_valid"}, 64'(o_valid[i]), 64'(m_v[i]));
        if (m_k[i]) begin
            chk({p, " pc_o"}, o_pc[i], m_pc[i]);
            chk({p, " instr_o"}, 64'(o_instr[i]), 64'(m_in[i]));
            chk({p, " imm_o"}, o_imm[i], m_im[i]);
            chk({p, " rd_o"}, 64'(o_rd[i]), 64'(m_rd[i]));
            chk({p, " rs1_data"}, o_r1[i], m_r1[i]);
            chk({p, " rs2_data"}, o_r2[i], m_r2[i]);
        end
        n_v[i] = m_v[i]; n_k[i] = m_k[i]; n_pc[i] = m_pc[i];
        n_im[i] = m_im[i]; n_r1[i] = m_r1[i]; n_r2[i] = m_r2[i];
        n_in[i] = m_in[i]; n_rd[i] = m_rd[i];
        if (s_flush) begin
            n_v[i] = 0;
            n_k[i] = 0;
        end else if (fire && s_in_valid && !hz) begin
            n_v[i] = 1; n_k[i] = 1; n_pc[i] = tr(s_pc, w);
            n_im[i] = im; n_r1[i] = v1; n_r2[i] = v2;
            n_in[i] = s_instr; n_rd[i] = s_instr[11:7];
        end else if (fire) begin
            n_v[i] = 0;
        end
    endtask

    // Compare process: inputs are stable from posedge+1 to next posedge.
    initial begin
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_k[i] = 1; m_pc[i] = 0; m_im[i] = 0;
            m_r1[i] = 0; m_r2[i] = 0; m_in[i] = 0; m_rd[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) check_inst(i);
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                m_v[i] = n_v[i]; m_k[i] = n_k[i]; m_pc[i] = n_pc[i];
                m_im[i] = n_im[i]; m_r1[i] = n_r1[i];
                m_r2[i] = n_r2[i]; m_in[i] = n_in[i]; m_rd[i] = n_rd[i];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        s_in_valid = 0; s_out_ready = 1; s_flush = 0; s_idx_src = 0;
        s_exw = 0; s_exl = 0; s_memw = 0; s_exrd = 0; s_memrd = 0;
    endtask

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h1;
            3: return 64'h0000_0000_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 10))
            0: x[6:0] = 7'h03;
            1: x[6:0] = 7'h13;
            2: x[6:0] = 7'h1B;
            3: x[6:0] = 7'h67;
            4: x[6:0] = 7'h23;
            5: x[6:0] = 7'h63;
            6: x[6:0] = 7'h37;
            7: x[6:0] = 7'h17;
            8: x[6:0] = 7'h6F;
            9: x[6:0] = 7'h33;
            default: x[6:0] = 7'h73;
        endcase
        x[19:15] = 5'($urandom_range(0, 4));
        x[24:20] = 5'($urandom_range(0, 4));
        return x;
    endfunction

    task automatic rnd_inputs();
        s_in_valid  = ($urandom_range(0, 9) < 8);
        s_out_ready = ($urandom_range(0, 3) != 0);
        s_flush     = ($urandom_range(0, 9) == 0);
        s_idx_src   = $urandom_range(0, 1) == 1;
        s_exw       = $urandom_range(0, 1) == 1;
        s_exl       = ($urandom_range(0, 9) < 3);
        s_memw      = $urandom_range(0, 1) == 1;
        s_exrd      = 5'($urandom_range(0, 4));
        s_memrd     = 5'($urandom_range(0, 4));
        s_instr     = rnd_instr();
        s_pc        = {$urandom, $urandom};
        s_rf1       = pick64();
        s_rf2       = pick64();
        s_exr       = pick64();
        s_memr      = pick64();
    endtask

    initial begin
        quiet();
        repeat (2) step();
        rst_n = 1;

        // addi x5,x0,-1
        s_in_valid = 1; s_instr = 32'hFFF00293; s_pc = 64'h100;
        step();
        chk("addi valid", 64'(o_valid[0]), 64'h1);
        chk("addi imm64", o_imm[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi imm32", o_imm[1], 64'h0000_0000_FFFF_FFFF);
        chk("addi rd", 64'(o_rd[0]), 64'h5);

        // asynchronous reset in the middle of a cycle
        #2 rst_n = 0;
        #1;
        chk("async rst valid", 64'(o_valid[0]), 64'h0);
        chk("async rst imm", o_imm[0], 64'h0);
        chk("async rst pc", o_pc[1], 64'h0);
        step();
        rst_n = 1;

        // forwarding priority: add x3,x1,x2
        s_instr = 32'h002081B3;
        s_exw = 1; s_exrd = 1; s_exr = 64'h11;
        s_memw = 1; s_memrd = 1; s_memr = 64'h22;
        s_rf1 = 64'h33; s_rf2 = 64'h44;
        step();
        chk("fwd ex prio", o_r1[0], 64'h11);
        chk("fwd ex prio32", o_r1[1], 64'h11);
        chk("fwd rf rs2", o_r2[0], 64'h44);

        // add x3,x0,x2 with rd=0 producers: x0 is never bypassed
        s_instr = 32'h002001B3; s_exrd = 0; s_memrd = 0;
        step();
        chk("fwd x0", o_r1[0], 64'h33);

        // load-use: EX lw x4, ID add x6,x4,x4
        s_instr = 32'h00420333;
        s_exw = 1; s_exl = 1; s_exrd = 4; s_memw = 0;
        #1;
        chk("lu stall", 64'(o_stall[0]), 64'h1);
        chk("lu in_ready", 64'(o_inrdy[0]), 64'h0);
        step();
        chk("lu bubble", 64'(o_valid[0]), 64'h0);
        s_exw = 0; s_exl = 0; s_memw = 1; s_memrd = 4;
        s_memr = 64'h55; s_rf1 = 64'h99; s_rf2 = 64'h98;
        #1;
        chk("lu accept", 64'(o_inrdy[0]), 64'h1);
        step();
        chk("lu rs1", o_r1[0], 64'h55);
        chk("lu rs2", o_r2[0], 64'h55);
        chk("lu valid", 64'(o_valid[0]), 64'h1);

        // backpressure
        s_out_ready = 0; s_memw = 0; s_instr = 32'h00108093;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp in_ready", 64'(o_inrdy[0]), 64'h0);
            step();
            s_rf1 = {$urandom, $urandom};
            chk("bp valid", 64'(o_valid[0]), 64'h1);
            chk("bp instr", 64'(o_instr[0]), 64'h00420333);
            chk("bp rs1", o_r1[0], 64'h55);
        end

        // flush
        s_out_ready = 1; s_flush = 1;
        #1;
        chk("flush in_ready", 64'(o_inrdy[0]), 64'h0);
        step();
        chk("flush valid", 64'(o_valid[0]), 64'h0);
        quiet();

        // beq x1,x2,-8
        s_pc = 64'h1000; s_instr = 32'hFE208CE3;
        s_rf1 = 64'hFFFF_FFFF_FFFF_FFFF; s_rf2 = 64'h1;
        #1;
        chk("beq target", o_br[0], 64'hFF8);
        chk("beq flags", 64'(o_flags[0]), 64'h2);
        chk("beq target32", o_br[1], 64'hFF8);
        chk("beq flags32", 64'(o_flags[1]), 64'h2);
        step();

        // jalr x1,4(x1)
        s_idx_src = 1; s_instr = 32'h004080E7; s_rf1 = 64'h2000;
        #1;
        chk("jalr target", o_br[0], 64'h2004);
        chk("jalr target32", o_br[1], 64'h2004);
        s_exw = 1; s_exrd = 1; s_exr = 64'h3000;
        #1;
        chk("jalr fwd", o_br[0], 64'h3004);
        chk("jalr nofwd", o_br[2], 64'h2004);
        step();
        quiet();

        for (int c = 0; c < 3000; c++) begin
            step();
            rnd_inputs();
            rst_n = (c != 1500);
        end
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
